// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor with one borrow flop
// Computes a - b LSB first over WIDTH cycles, then holds the result under valid/ack.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             valid,
  input  logic             ack
);

  // One extra counter bit keeps WIDTH=1 and power-of-two widths representable.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             dbit;
  logic             br_nxt;
  logic [WIDTH:0]   res_cat;

  always_comb begin
    x       = opa[0];
    y       = opb[0];
    dbit    = x ^ y ^ br;
    br_nxt  = (~x & y) | (~(x ^ y) & br);
    res_cat = {dbit, res};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
      res <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa <= a;
            opb <= b;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
          opa <= opa >> 1;
          opb <= opb >> 1;
          res <= res_cat[WIDTH:1];
          br  <= br_nxt;
          cnt <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign valid = (state == DONE);
  assign d     = res;
  assign bout  = br;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
// Exercises WIDTH=8 and WIDTH=1 instances against a plain-arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ack8 = 1'b0;
  logic       ready8;
  logic [7:0] d8;
  logic       bout8;
  logic       valid8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       ack1 = 1'b0;
  logic       ready1;
  logic [0:0] d1;
  logic       bout1;
  logic       valid1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .d(d8), .bout(bout8), .valid(valid8), .ack(ack8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .d(d1), .bout(bout1), .valid(valid1), .ack(ack1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 8) ? ready8 : ready1;
  endfunction

  function automatic logic vld(input int w);
    return (w == 8) ? valid8 : valid1;
  endfunction

  function automatic logic [7:0] dif(input int w);
    return (w == 8) ? d8 : {7'd0, d1};
  endfunction

  function automatic logic brw(input int w);
    return (w == 8) ? bout8 : bout1;
  endfunction

  task automatic set_in(input int w, input logic s, input logic [7:0] av,
                        input logic [7:0] bv, input logic k);
    if (w == 8) begin
      start8 = s; a8 = av; b8 = bv; ack8 = k;
    end else begin
      start1 = s; a1 = av[0]; b1 = bv[0]; ack1 = k;
    end
  endtask

  // One full transaction with cycle-accurate handshake checks; inj pulses stray starts.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input int hold, input bit inj);
    logic [7:0] mask;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] exp_d;
    logic       exp_b;
    mask  = (w == 8) ? 8'hFF : 8'h01;
    ea    = av & mask;
    eb    = bv & mask;
    exp_d = (ea - eb) & mask;
    exp_b = (ea < eb);
    check("ready_before_start", 32'(rdy(w)), 32'd1);
    set_in(w, 1'b1, ea, eb, 1'b0);
    step();
    for (int cyc = 1; cyc <= w; cyc++) begin
      check("ready_low_run", 32'(rdy(w)), 32'd0);
      check("valid_low_run", 32'(vld(w)), 32'd0);
      set_in(w, inj && (cyc == 2), 8'($urandom), 8'($urandom), 1'($urandom));
      step();
    end
    check("valid_at_latency", 32'(vld(w)), 32'd1);
    check("ready_low_done", 32'(rdy(w)), 32'd0);
    check("d_result", 32'(dif(w)), 32'(exp_d));
    check("bout_result", 32'(brw(w)), 32'(exp_b));
    for (int h = 0; h < hold; h++) begin
      set_in(w, inj, 8'($urandom), 8'($urandom), 1'b0);
      step();
      check("valid_hold", 32'(vld(w)), 32'd1);
      check("d_hold", 32'(dif(w)), 32'(exp_d));
      check("bout_hold", 32'(brw(w)), 32'(exp_b));
    end
    set_in(w, inj, 8'($urandom), 8'($urandom), 1'b1);
    step();
    set_in(w, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
    check("ready_after_ack", 32'(rdy(w)), 32'd1);
    check("valid_after_ack", 32'(vld(w)), 32'd0);
    if (inj) begin
      step();
      check("no_extra_op_ready", 32'(rdy(w)), 32'd1);
      check("no_extra_op_valid", 32'(vld(w)), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    check("rst_ready8", 32'(ready8), 32'd1);
    check("rst_valid8", 32'(valid8), 32'd0);
    check("rst_d8", 32'(d8), 32'd0);
    check("rst_bout8", 32'(bout8), 32'd0);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_valid1", 32'(valid1), 32'd0);
    rst = 1'b0;
    step();

    run_op(8, 8'h5A, 8'h23, 0, 1'b0);
    run_op(8, 8'h00, 8'h01, 0, 1'b0);
    run_op(8, 8'hFF, 8'hFF, 0, 1'b0);
    run_op(8, 8'h80, 8'h7F, 0, 1'b0);
    run_op(8, 8'h7F, 8'h80, 0, 1'b0);
    run_op(8, 8'hC3, 8'h3C, 5, 1'b0);
    run_op(8, 8'h12, 8'h34, 2, 1'b1);

    // Abort in cycle 4 of RUN.
    set_in(8, 1'b1, 8'h5A, 8'h23, 1'b0);
    step();
    set_in(8, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", 32'(ready8), 32'd1);
    check("abort_valid", 32'(valid8), 32'd0);
    check("abort_d", 32'(d8), 32'd0);
    check("abort_bout", 32'(bout8), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort_no_valid", 32'(valid8), 32'd0);
    end
    run_op(8, 8'h10, 8'h01, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op(8, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    run_op(1, 8'h00, 8'h01, 0, 1'b0);
    run_op(1, 8'h01, 8'h01, 0, 1'b0);
    run_op(1, 8'h01, 8'h00, 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_op(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
